// File: rtl/key_entry_buffer.sv
// Keypad digit-entry buffer: edits up to DIGITS BCD digits and commits them on enter.
// Define KEY_BEEP_EN to build the key-acknowledge beep generator; otherwise beep is tied low.
module key_entry_buffer #(
    parameter int DIGITS     = 4,
    parameter int TIMEOUT    = 50000,
    parameter int BEEP_TICKS = 500
) (
    input  logic                         clk_10k,
    input  logic                         rst_n,
    input  logic [3:0]                   key_code,
    input  logic                         key_valid,
    output logic [4*DIGITS-1:0]          entry_bcd,
    output logic [$clog2(DIGITS+1)-1:0]  entry_len,
    output logic                         editing,
    output logic [4*DIGITS-1:0]          value_bcd,
    output logic                         commit,
    output logic                         beep
);
    localparam int LW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] LEN_FULL   = LW'(DIGITS);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ENTRY, COMMIT} state_t;

    state_t              state_reg, state_next;
    logic [4*DIGITS-1:0] entry_reg, entry_next;
    logic [4*DIGITS-1:0] value_reg, value_next;
    logic [LW-1:0]       len_reg, len_next;
    logic [TW-1:0]       timer_reg, timer_next;
    logic                ack_single, ack_double;
    logic                is_digit, is_bksp, is_clear, is_enter;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_bksp  = key_valid && (key_code == 4'hA);
    assign is_clear = key_valid && (key_code == 4'hB);
    assign is_enter = key_valid && (key_code == 4'hC);

    always_ff @(posedge clk_10k or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            entry_reg <= '0;
            value_reg <= '0;
            len_reg   <= '0;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            entry_reg <= entry_next;
            value_reg <= value_next;
            len_reg   <= len_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        entry_next = entry_reg;
        value_next = value_reg;
        len_next   = len_reg;
        timer_next = timer_reg;
        ack_single = 1'b0;
        ack_double = 1'b0;
        case (state_reg)
            ENTRY: begin
                if (is_digit) begin
                    timer_next = TIMER_LOAD;
                    if (len_reg < LEN_FULL) begin
                        entry_next = {entry_reg[4*DIGITS-5:0], key_code};
                        len_next   = len_reg + 1'b1;
                        ack_single = 1'b1;
                    end else begin
                        ack_double = 1'b1;
                    end
                end else if (is_bksp) begin
                    entry_next = {4'h0, entry_reg[4*DIGITS-1:4]};
                    len_next   = len_reg - 1'b1;
                    timer_next = TIMER_LOAD;
                    ack_single = 1'b1;
                    if (len_reg == LW'(1)) begin
                        state_next = IDLE;
                    end
                end else if (is_clear) begin
                    entry_next = '0;
                    len_next   = '0;
                    timer_next = '0;
                    ack_single = 1'b1;
                    state_next = IDLE;
                end else if (is_enter) begin
                    value_next = entry_reg;
                    entry_next = '0;
                    len_next   = '0;
                    timer_next = TIMER_LOAD;
                    ack_single = 1'b1;
                    state_next = COMMIT;
                end else if (timer_reg <= TW'(1)) begin
                    // Idle too long: abandon the entry without touching value_bcd.
                    entry_next = '0;
                    len_next   = '0;
                    timer_next = '0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: begin
                // IDLE and the single COMMIT cycle share the same key rules so no key is lost.
                state_next = IDLE;
                if (is_digit) begin
                    entry_next = {{(4*DIGITS-4){1'b0}}, key_code};
                    len_next   = LW'(1);
                    timer_next = TIMER_LOAD;
                    ack_single = 1'b1;
                    state_next = ENTRY;
                end
            end
        endcase
    end

    assign entry_bcd = entry_reg;
    assign entry_len = len_reg;
    assign editing   = (state_reg == ENTRY);
    assign value_bcd = value_reg;
    assign commit    = (state_reg == COMMIT);

`ifdef KEY_BEEP_EN
    localparam int BW = $clog2(3 * BEEP_TICKS + 1);
    localparam logic [BW-1:0] BEEP_ONE   = BW'(BEEP_TICKS);
    localparam logic [BW-1:0] BEEP_TWO   = BW'(2 * BEEP_TICKS);
    localparam logic [BW-1:0] BEEP_THREE = BW'(3 * BEEP_TICKS);

    logic [BW-1:0] beep_cnt_reg;
    logic          beep_dbl_reg;

    always_ff @(posedge clk_10k or negedge rst_n) begin
        if (!rst_n) begin
            beep_cnt_reg <= '0;
            beep_dbl_reg <= 1'b0;
        end else if (ack_double) begin
            beep_cnt_reg <= BEEP_THREE;
            beep_dbl_reg <= 1'b1;
        end else if (ack_single) begin
            beep_cnt_reg <= BEEP_ONE;
            beep_dbl_reg <= 1'b0;
        end else if (beep_cnt_reg != '0) begin
            beep_cnt_reg <= beep_cnt_reg - 1'b1;
        end
    end

    // Double beep is on-off-on over 3*BEEP_TICKS; the middle third is silent.
    assign beep = (beep_cnt_reg != '0) &&
                  !(beep_dbl_reg && (beep_cnt_reg > BEEP_ONE) && (beep_cnt_reg <= BEEP_TWO));
`else
    logic beep_unused;
    assign beep_unused = ack_single | ack_double | (BEEP_TICKS == 0);
    assign beep        = 1'b0;
`endif

endmodule
